// File: rtl/nn_loader_pkg.sv
// Shared header layout, packet types, FSM states and header struct for the parameter loader.
package nn_loader_pkg;

    localparam int HDR_TYPE_LSB   = 28;
    localparam int HDR_LAYER_LSB  = 24;
    localparam int HDR_NEURON_LSB = 12;
    localparam int HDR_COUNT_LSB  = 0;
    localparam int COUNT_WIDTH    = 12;

    typedef enum logic [3:0] {
        PKT_WEIGHT = 4'h1,
        PKT_BIAS   = 4'h2,
        PKT_COMMIT = 4'hF
    } pkt_type_t;

    typedef enum logic [1:0] {
        S_HDR,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    // Field order matches the header word, MSB first.
    typedef struct packed {
        logic [3:0]             pkt_type;
        logic [3:0]             layer;
        logic [11:0]            neuron;
        logic [COUNT_WIDTH-1:0] count;
    } hdr_t;

    function automatic hdr_t decode_hdr(input logic [31:0] word);
        return hdr_t'(word);
    endfunction

endpackage

// File: rtl/param_loader_if.sv
// AXI-stream slave bundle feeding the parameter loader.
interface param_loader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] s_axis_data;
    logic                  s_axis_valid;
    logic                  s_axis_last;
    logic                  s_axis_ready;

    modport master (output s_axis_data, output s_axis_valid, output s_axis_last, input  s_axis_ready);
    modport slave  (input  s_axis_data, input  s_axis_valid, input  s_axis_last, output s_axis_ready);
endinterface

// File: rtl/param_loader.sv
// Decodes framed parameter packets into one-cycle weight/bias strobes with held layer/neuron IDs.
// Optional trailing XOR checksum word per weight/bias packet: define PARAM_LOADER_CHECKSUM_EN.
module param_loader
    import nn_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LAYERS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    param_loader_if.slave         axis,
    output logic [DATA_WIDTH-1:0] o_weight,
    output logic                  o_weight_valid,
    output logic [DATA_WIDTH-1:0] o_bias,
    output logic                  o_bias_valid,
    output logic [31:0]           o_layer_id,
    output logic [31:0]           o_neuron_id,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [3:0] MAX_LAYER = NUM_LAYERS[3:0];

    state_t                  state_reg;
    logic [COUNT_WIDTH-1:0]  count_reg;
    logic [COUNT_WIDTH-1:0]  n_reg;
    logic                    is_bias_reg;
    logic                    ready_reg;
    logic [DATA_WIDTH-1:0]   weight_reg;
    logic                    weight_valid_reg;
    logic [DATA_WIDTH-1:0]   bias_reg;
    logic                    bias_valid_reg;
    logic [3:0]              layer_reg;
    logic [11:0]             neuron_reg;
    logic                    done_reg;
    logic                    error_reg;
`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   csum_reg;
`endif

    hdr_t                    hdr;
    logic                    accept;
    logic                    last;
    logic                    layer_ok;
    logic                    wb_ok;
    logic                    weight_ok;
    logic                    bias_ok;
    logic                    commit_ok;
    logic [COUNT_WIDTH-1:0]  count_next;

    assign hdr        = decode_hdr(axis.s_axis_data[31:0]);
    assign accept     = axis.s_axis_valid & ready_reg;
    assign last       = axis.s_axis_last;
    assign layer_ok   = (hdr.layer != 4'd0) && (hdr.layer <= MAX_LAYER);
    assign wb_ok      = layer_ok && (hdr.count != '0) && !last;
    assign weight_ok  = (hdr.pkt_type == PKT_WEIGHT) && wb_ok;
    assign bias_ok    = (hdr.pkt_type == PKT_BIAS) && wb_ok && (hdr.count == 12'd1);
    assign commit_ok  = (hdr.pkt_type == PKT_COMMIT) && (hdr.count == '0) && last;
    assign count_next = count_reg + 12'd1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg        <= S_HDR;
            count_reg        <= '0;
            n_reg            <= '0;
            is_bias_reg      <= 1'b0;
            ready_reg        <= 1'b0;
            weight_reg       <= '0;
            weight_valid_reg <= 1'b0;
            bias_reg         <= '0;
            bias_valid_reg   <= 1'b0;
            layer_reg        <= '0;
            neuron_reg       <= '0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
            csum_reg         <= '0;
`endif
        end else begin
            ready_reg        <= 1'b1;
            weight_valid_reg <= 1'b0;
            bias_valid_reg   <= 1'b0;
            if (accept) begin
                case (state_reg)
                    S_HDR: begin
                        if (weight_ok || bias_ok) begin
                            layer_reg   <= hdr.layer;
                            neuron_reg  <= hdr.neuron;
                            n_reg       <= hdr.count;
                            count_reg   <= '0;
                            is_bias_reg <= bias_ok;
                            done_reg    <= 1'b0;
                            state_reg   <= S_PAYLOAD;
`ifdef PARAM_LOADER_CHECKSUM_EN
                            csum_reg    <= axis.s_axis_data;
`endif
                        end else if (commit_ok) begin
                            done_reg <= 1'b1;
                        end else begin
                            error_reg <= 1'b1;
                            state_reg <= last ? S_HDR : S_DRAIN;
                        end
                    end
                    S_PAYLOAD: begin
`ifdef PARAM_LOADER_CHECKSUM_EN
                        // Once all N beats are in, the next word is the checksum and strobes nothing.
                        if (count_reg == n_reg) begin
                            if (!last) begin
                                error_reg <= 1'b1;
                                state_reg <= S_DRAIN;
                            end else begin
                                if (axis.s_axis_data != csum_reg) error_reg <= 1'b1;
                                state_reg <= S_HDR;
                            end
                        end else begin
                            if (is_bias_reg) begin
                                bias_reg       <= axis.s_axis_data;
                                bias_valid_reg <= 1'b1;
                            end else begin
                                weight_reg       <= axis.s_axis_data;
                                weight_valid_reg <= 1'b1;
                            end
                            count_reg <= count_next;
                            csum_reg  <= csum_reg ^ axis.s_axis_data;
                            if (last) begin
                                error_reg <= 1'b1;
                                state_reg <= S_HDR;
                            end
                        end
`else
                        if (is_bias_reg) begin
                            bias_reg       <= axis.s_axis_data;
                            bias_valid_reg <= 1'b1;
                        end else begin
                            weight_reg       <= axis.s_axis_data;
                            weight_valid_reg <= 1'b1;
                        end
                        count_reg <= count_next;
                        if (count_next == n_reg) begin
                            if (!last) begin
                                error_reg <= 1'b1;
                                state_reg <= S_DRAIN;
                            end else begin
                                state_reg <= S_HDR;
                            end
                        end else if (last) begin
                            error_reg <= 1'b1;
                            state_reg <= S_HDR;
                        end
`endif
                    end
                    S_DRAIN: begin
                        if (last) state_reg <= S_HDR;
                    end
                    default: state_reg <= S_HDR;
                endcase
            end
        end
    end

    assign axis.s_axis_ready = ready_reg;
    assign o_weight          = weight_reg;
    assign o_weight_valid    = weight_valid_reg;
    assign o_bias            = bias_reg;
    assign o_bias_valid      = bias_valid_reg;
    assign o_layer_id        = {28'd0, layer_reg};
    assign o_neuron_id       = {20'd0, neuron_reg};
    assign o_busy            = (state_reg != S_HDR);
    assign o_done            = done_reg;
    assign o_error           = error_reg;

endmodule

// File: tb/tb_param_loader.sv
// Directed self-checking bench for param_loader; follows PARAM_LOADER_CHECKSUM_EN when defined.
module tb_param_loader;

    logic        clk;
    logic        rst_n;
    logic [31:0] o_weight;
    logic        o_weight_valid;
    logic [31:0] o_bias;
    logic        o_bias_valid;
    logic [31:0] o_layer_id;
    logic [31:0] o_neuron_id;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    param_loader_if #(.DATA_WIDTH(32)) axis_if ();

    param_loader #(.DATA_WIDTH(32), .NUM_LAYERS(4)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .axis           (axis_if.slave),
        .o_weight       (o_weight),
        .o_weight_valid (o_weight_valid),
        .o_bias         (o_bias),
        .o_bias_valid   (o_bias_valid),
        .o_layer_id     (o_layer_id),
        .o_neuron_id    (o_neuron_id),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] w_data[$];
    logic [31:0] w_layer[$];
    logic [31:0] w_neuron[$];
    int          w_cyc[$];
    logic [31:0] b_data[$];
    logic [31:0] b_layer[$];
    logic [31:0] b_neuron[$];
    logic [31:0] pay[0:15];

    always @(posedge clk) cyc <= cyc + 1;

    // Strobes are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_weight_valid) begin
                w_data.push_back(o_weight);
                w_layer.push_back(o_layer_id);
                w_neuron.push_back(o_neuron_id);
                w_cyc.push_back(cyc);
            end
            if (o_bias_valid) begin
                b_data.push_back(o_bias);
                b_layer.push_back(o_layer_id);
                b_neuron.push_back(o_neuron_id);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        w_data.delete(); w_layer.delete(); w_neuron.delete(); w_cyc.delete();
        b_data.delete(); b_layer.delete(); b_neuron.delete();
    endtask

    task automatic send_word(input logic [31:0] data, input logic last);
        axis_if.s_axis_data  = data;
        axis_if.s_axis_last  = last;
        axis_if.s_axis_valid = 1'b1;
        @(posedge clk);
        #1;
        axis_if.s_axis_valid = 1'b0;
        axis_if.s_axis_last  = 1'b0;
    endtask

    // Header, then pay[0..n-1] back-to-back; the checksum word (if built in) carries last.
    task automatic send_pkt(input logic [31:0] hdr, input int n, input logic [31:0] csum_flip);
        logic [31:0] x;
        x = hdr;
        send_word(hdr, 1'b0);
        for (int i = 0; i < n; i++) begin
            x = x ^ pay[i];
`ifdef PARAM_LOADER_CHECKSUM_EN
            send_word(pay[i], 1'b0);
`else
            send_word(pay[i], i == n - 1);
`endif
        end
`ifdef PARAM_LOADER_CHECKSUM_EN
        send_word(x ^ csum_flip, 1'b1);
`endif
        $display("pkt hdr=0x%08h beats=%0d csum_flip=0x%08h", hdr, n, csum_flip);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        rst_n = 1'b0;
        axis_if.s_axis_data  = '0;
        axis_if.s_axis_valid = 1'b0;
        axis_if.s_axis_last  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'd0, axis_if.s_axis_ready}, 32'd0);
        check_eq("rst_busy",  {31'd0, o_busy}, 32'd0);
        check_eq("rst_flags", {30'd0, o_done, o_error}, 32'd0);
        check_eq("rst_layer", o_layer_id, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check_eq("ready_after_rst", {31'd0, axis_if.s_axis_ready}, 32'd1);

        // Weight packet L2 neuron 5, three back-to-back beats
        clear_log();
        pay[0] = 32'h11; pay[1] = 32'h22; pay[2] = 32'h33;
        send_word(32'h1200_5003, 1'b0);
        check_eq("w3_busy_mid", {31'd0, o_busy}, 32'd1);
        send_word(pay[0], 1'b0);
        send_word(pay[1], 1'b0);
`ifdef PARAM_LOADER_CHECKSUM_EN
        send_word(pay[2], 1'b0);
        send_word(32'h1200_5003 ^ 32'h11 ^ 32'h22 ^ 32'h33, 1'b1);
`else
        send_word(pay[2], 1'b1);
`endif
        $display("pkt hdr=0x12005003 beats=3");
        idle(2);
        check_eq("w3_count", w_data.size(), 32'd3);
        if (w_data.size() == 3) begin
            check_eq("w3_d0", w_data[0], 32'h11);
            check_eq("w3_d1", w_data[1], 32'h22);
            check_eq("w3_d2", w_data[2], 32'h33);
            check_eq("w3_consecutive", w_cyc[2] - w_cyc[0], 32'd2);
            for (int i = 0; i < 3; i++) begin
                check_eq("w3_layer", w_layer[i], 32'd2);
                check_eq("w3_neuron", w_neuron[i], 32'd5);
            end
        end
        check_eq("w3_bias_none", b_data.size(), 32'd0);
        check_eq("w3_error", {31'd0, o_error}, 32'd0);
        check_eq("w3_busy_end", {31'd0, o_busy}, 32'd0);

        // Bias packet L4 neuron 9
        clear_log();
        pay[0] = 32'hDEAD_BEEF;
        send_pkt(32'h2400_9001, 1, 32'd0);
        idle(2);
        check_eq("b1_count", b_data.size(), 32'd1);
        if (b_data.size() == 1) begin
            check_eq("b1_data", b_data[0], 32'hDEAD_BEEF);
            check_eq("b1_layer", b_layer[0], 32'd4);
            check_eq("b1_neuron", b_neuron[0], 32'd9);
        end
        check_eq("b1_no_weight", w_data.size(), 32'd0);
        check_eq("b1_error", {31'd0, o_error}, 32'd0);

        // Illegal layer 7: whole packet drained, IDs untouched
        clear_log();
        send_word(32'h1700_0004, 1'b0);
        check_eq("bad_busy_drain", {31'd0, o_busy}, 32'd1);
        for (int i = 0; i < 4; i++) send_word(32'hA0 + i, i == 3);
        $display("pkt hdr=0x17000004 beats=4 (illegal layer)");
        idle(2);
        check_eq("bad_error", {31'd0, o_error}, 32'd1);
        check_eq("bad_no_strobe", w_data.size() + b_data.size(), 32'd0);
        check_eq("bad_busy_end", {31'd0, o_busy}, 32'd0);
        check_eq("bad_layer_held", o_layer_id, 32'd4);
        check_eq("bad_neuron_held", o_neuron_id, 32'd9);

        // Following legal packet loads normally
        clear_log();
        pay[0] = 32'h0A; pay[1] = 32'h0B;
        send_pkt(32'h1100_3002, 2, 32'd0);
        idle(2);
        check_eq("after_bad_count", w_data.size(), 32'd2);
        if (w_data.size() == 2) begin
            check_eq("after_bad_d1", w_data[1], 32'h0B);
            check_eq("after_bad_layer", w_layer[0], 32'd1);
            check_eq("after_bad_neuron", w_neuron[1], 32'd3);
        end

        // Early last on beat 2 of N=4, then commit
        do_reset();
        check_eq("reset_clears_error", {31'd0, o_error}, 32'd0);
        clear_log();
        send_word(32'h1300_1004, 1'b0);
        send_word(32'h01, 1'b0);
        send_word(32'h02, 1'b1);
        $display("pkt hdr=0x13001004 beats=2 (early last)");
        idle(2);
        check_eq("early_count", w_data.size(), 32'd2);
        check_eq("early_error", {31'd0, o_error}, 32'd1);
        check_eq("early_busy", {31'd0, o_busy}, 32'd0);
        check_eq("early_done_pre", {31'd0, o_done}, 32'd0);
        send_word(32'hF000_0000, 1'b1);
        $display("pkt hdr=0xF0000000 commit");
        idle(1);
        check_eq("commit_done", {31'd0, o_done}, 32'd1);
        check_eq("commit_busy", {31'd0, o_busy}, 32'd0);

        // Reset between beats 1 and 2 of an N=3 packet
        clear_log();
        send_word(32'h1200_A003, 1'b0);
        check_eq("hdr_clears_done", {31'd0, o_done}, 32'd0);
        send_word(32'h55, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_strobe", {31'd0, o_weight_valid}, 32'd0);
        check_eq("midrst_busy", {31'd0, o_busy}, 32'd0);
        check_eq("midrst_error", {31'd0, o_error}, 32'd0);
        check_eq("midrst_ready", {31'd0, axis_if.s_axis_ready}, 32'd0);
        check_eq("midrst_layer", o_layer_id, 32'd0);
        check_eq("midrst_weight", o_weight, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check_eq("midrst_ready_after", {31'd0, axis_if.s_axis_ready}, 32'd1);
        check_eq("midrst_dropped", w_data.size(), 32'd0);
        clear_log();
        pay[0] = 32'h77;
        send_pkt(32'h2100_2001, 1, 32'd0);
        idle(2);
        check_eq("fresh_count", b_data.size(), 32'd1);
        if (b_data.size() == 1) begin
            check_eq("fresh_data", b_data[0], 32'h77);
            check_eq("fresh_layer", b_layer[0], 32'd1);
            check_eq("fresh_neuron", b_neuron[0], 32'd2);
        end
        check_eq("fresh_error", {31'd0, o_error}, 32'd0);

`ifdef PARAM_LOADER_CHECKSUM_EN
        // Good checksum, then corrupted checksum
        clear_log();
        pay[0] = 32'h1234_5678; pay[1] = 32'h0F0F_0F0F;
        send_pkt(32'h1300_4002, 2, 32'd0);
        idle(2);
        check_eq("csum_ok_count", w_data.size(), 32'd2);
        check_eq("csum_ok_error", {31'd0, o_error}, 32'd0);
        check_eq("csum_ok_busy", {31'd0, o_busy}, 32'd0);
        clear_log();
        send_pkt(32'h1300_4002, 2, 32'h0000_0100);
        idle(2);
        check_eq("csum_bad_count", w_data.size(), 32'd2);
        check_eq("csum_bad_error", {31'd0, o_error}, 32'd1);
        check_eq("csum_bad_busy", {31'd0, o_busy}, 32'd0);
`else
        // Beat N without last: error, rest drained
        clear_log();
        send_word(32'h1200_0001, 1'b0);
        send_word(32'h99, 1'b0);
        check_eq("overrun_busy", {31'd0, o_busy}, 32'd1);
        send_word(32'h98, 1'b1);
        $display("pkt hdr=0x12000001 beats=2 (missing last)");
        idle(2);
        check_eq("overrun_count", w_data.size(), 32'd1);
        if (w_data.size() == 1) check_eq("overrun_data", w_data[0], 32'h99);
        check_eq("overrun_error", {31'd0, o_error}, 32'd1);
        check_eq("overrun_busy_end", {31'd0, o_busy}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/param_loader.md
# param_loader

Streams trained network parameters into the neural network's weight/bias load port. An AXI-stream slave accepts framed parameter packets from the host/DMA, decodes each header, and emits the payload as one-cycle weight or bias strobes with stable layer/neuron IDs. It is the writer side of the `i_weight`/`i_bias`/`i_layer_id`/`i_neuron_id` interface that every layer reads.

## Interface
- `DATA_WIDTH`, 32, width of stream words and of the weight/bias words.
- `NUM_LAYERS`, 4, highest legal layer ID; legal IDs are 1..NUM_LAYERS.
- `i_clk` in 1, the single clock.
- `i_reset_n` in 1, asynchronous active-low reset.
- `i_s_axis_data` in DATA_WIDTH, packet word.
- `i_s_axis_valid` in 1, word valid.
- `i_s_axis_last` in 1, last word of packet.
- `o_s_axis_ready` out 1, word accepted when valid&ready.
- `o_weight` out 32, weight word.
- `o_weight_valid` out 1, one-cycle weight strobe.
- `o_bias` out 32, bias word.
- `o_bias_valid` out 1, one-cycle bias strobe.
- `o_layer_id` out 32, target layer, zero-extended.
- `o_neuron_id` out 32, target neuron, zero-extended.
- `o_busy` out 1, packet in progress.
- `o_done` out 1, sticky commit seen.
- `o_error` out 1, sticky format error.

## Operation
- Header word: [31:28] type (0x1 weight, 0x2 bias, 0xF commit); [27:24] layer ID; [23:12] neuron ID; [11:0] count N.
- States: S_HDR, S_PAYLOAD, S_DRAIN.
- S_HDR, weight header: requires N≥1, legal layer, no `last`. Latch IDs and N, clear beat counter, go S_PAYLOAD, clear `o_done`.
- S_HDR, bias header: same checks, plus N must equal 1.
- S_HDR, commit header: requires N=0 and `last`. Sets `o_done`, stays in S_HDR.
- Any header violation sets `o_error`. If the header beat carried `last`, stay in S_HDR; otherwise go to S_DRAIN.
- S_PAYLOAD: each accepted beat produces a strobe on the next cycle and increments the counter.
- Beat N with `last` returns to S_HDR.
- Beat N without `last`: set `o_error`, go to S_DRAIN.
- `last` before beat N: set `o_error`, go to S_HDR. Beats already strobed are not retracted.
- S_DRAIN: discard beats until `last` is accepted, then go to S_HDR.
- `o_layer_id`/`o_neuron_id` update only on acceptance of a valid weight/bias header. They are held through the final strobe and until the next such header.
- `o_busy` = state ≠ S_HDR.

## Timing
- Reset (async assert, sync release): all outputs 0, state S_HDR, counter 0. `o_s_axis_ready` is 0 during reset and 1 from the first clock edge after release.
- `o_s_axis_ready` stays 1 in all states; the loader never back-pressures.
- Latency: payload beat accepted on edge t → data and strobe valid for exactly the cycle after t. Back-to-back beats give back-to-back strobes; a bubble on valid gives a bubble on strobe.
- IDs are valid no later than the first strobe of a packet and do not change while any strobe is high.
- Reset mid-packet: the packet is abandoned, any pending strobe is dropped, and `o_done`/`o_error` are cleared.
- The counter is 12 bits and compares against the latched N; there is no wrap.

## Configuration
- `PARAM_LOADER_CHECKSUM_EN`:
  - Defined: each weight/bias packet carries one extra final word, after the N payload beats, holding the XOR of the header and all payload words.
  - `last` must arrive on that word, not on beat N. The word produces no strobe.
  - A mismatch sets `o_error` and returns to S_HDR.
  - Commit packets carry no checksum.
- Undefined: no checksum word, and `last` is on beat N.

## Structure
- Package `nn_loader_pkg`: header field positions, type enum (PKT_WEIGHT, PKT_BIAS, PKT_COMMIT), state enum, header struct typedef.
- Single module; header decode stays inline. No sub-module.

## Test plan
- Weight packet {type 1, L2, neuron 5, N=3}, data 0x11, 0x22, 0x33 back-to-back with `last` on 0x33 → three consecutive `o_weight_valid` pulses; `o_layer_id`=2 and `o_neuron_id`=5 held throughout; `o_error`=0.
- Bias packet {type 2, L4, neuron 9, N=1}, data 0xDEADBEEF → one `o_bias_valid` pulse carrying 0xDEADBEEF; no weight strobe.
- Header with layer 7, N=4 without `last`, then 4 beats with `last` on the 4th → `o_error`=1, no strobes; the next legal packet loads normally.
- Weight packet N=4 with `last` on beat 2 → two strobes, `o_error`=1, state S_HDR; a following commit packet {0xF, N=0, `last`} → `o_done`=1.
- Reset asserted between beats 1 and 2 of an N=3 packet → outputs 0 immediately; after release `o_s_axis_ready`=1 and a fresh packet loads.
- With `PARAM_LOADER_CHECKSUM_EN`: correct XOR word → no error; corrupted XOR word → `o_error`=1 after the strobes.
